// File: rtl/odelay_tap_pkg.sv
// Shared definitions for the output-delay tap controller.
//   DEF_TAP_W          : default tap width (7-series delay count port)
//   TAP_MAX            : largest tap value at the default width
//   odelay_tap_state_t : controller FSM state encoding
// Honours ODELAY_TAP_CTL_READBACK_EN (adds the CHECK state).
package odelay_tap_pkg;

  localparam int unsigned DEF_TAP_W = 5;
  localparam logic [DEF_TAP_W-1:0] TAP_MAX = '1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE
`ifdef ODELAY_TAP_CTL_READBACK_EN
    , ST_CHECK
`endif
  } odelay_tap_state_t;

endpackage

// File: rtl/odelay_settle_timer.sv
// Loadable down-counter timing the settle interval after each tap load.
//   clk, rst : clock, asynchronous active-high reset
//   start    : reload the counter (pulse on the cycle before settling)
//   expired  : high on the last settle cycle and whenever idle
module odelay_settle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Reload with CYCLES-1 so that expired rises on the CYCLES-th cycle after start.
  localparam logic [CW-1:0] RELOAD = (CYCLES > 0) ? CW'(CYCLES - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/odelay_tap_ctl.sv
// Tap-sequencing controller driving the 7-series output delay load port.
// Walks the delay line to a requested tap (ramp or direct), settling after
// each load and optionally verifying the readback count.
//   clk, rst     : clock (also the delay element C), async active-high reset
//   req_valid/req_tap/req_ready : target request handshake
//   cntvaluein, ld : load value / one-cycle load strobe to the delay element
//   cntvalueout  : readback count from the delay element
//   tap_now      : last tap loaded
//   done         : one-cycle completion pulse
//   err, err_clr : sticky readback-mismatch flag and its clear
// Optional feature macro: ODELAY_TAP_CTL_READBACK_EN (readback CHECK state).
module odelay_tap_ctl
  import odelay_tap_pkg::*;
#(
  parameter int unsigned      TAP_W         = DEF_TAP_W,
  parameter logic [TAP_W-1:0] INIT_TAP      = '0,
  parameter bit               STEP_MODE     = 1'b1,
  parameter int unsigned      SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [TAP_W-1:0] req_tap,
  output logic             req_ready,
  output logic [TAP_W-1:0] cntvaluein,
  output logic             ld,
  input  logic [TAP_W-1:0] cntvalueout,
  output logic [TAP_W-1:0] tap_now,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  odelay_tap_state_t state;
  logic [TAP_W-1:0]  target;
  logic              direct_q;
  logic [TAP_W-1:0]  next_tap;
  logic              settle_expired;

  // Unsigned walk: move one tap toward the target, never through wrap.
  always_comb begin
    next_tap = target;
    if (!direct_q) begin
      next_tap = (tap_now < target) ? tap_now + 1'b1 : tap_now - 1'b1;
    end
  end

  odelay_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .start   (state == ST_LOAD),
    .expired (settle_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      ld         <= 1'b0;
      done       <= 1'b0;
      req_ready  <= 1'b0;
      cntvaluein <= INIT_TAP;
      tap_now    <= INIT_TAP;
      target     <= INIT_TAP;
      direct_q   <= 1'b1;
    end else begin
      ld   <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          target   <= INIT_TAP;
          direct_q <= 1'b1;
          state    <= ST_LOAD;
        end
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            target   <= req_tap;
            direct_q <= !STEP_MODE;
            if (req_tap == tap_now) begin
              done <= 1'b1;
            end else begin
              req_ready <= 1'b0;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          ld         <= 1'b1;
          cntvaluein <= next_tap;
          tap_now    <= next_tap;
          if (SETTLE_CYCLES != 0) begin
            state <= ST_SETTLE;
          end
`ifdef ODELAY_TAP_CTL_READBACK_EN
          else begin
            state <= ST_CHECK;
          end
`else
          // No settle and no readback: the step ends here, judged on next_tap.
          else if (next_tap == target) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
`endif
        end
        ST_SETTLE: begin
          if (settle_expired) begin
`ifdef ODELAY_TAP_CTL_READBACK_EN
            state <= ST_CHECK;
`else
            if (tap_now == target) begin
              done      <= 1'b1;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
`endif
          end
        end
`ifdef ODELAY_TAP_CTL_READBACK_EN
        ST_CHECK: begin
          // A mismatch aborts the remaining ramp.
          if (cntvalueout != tap_now || tap_now == target) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
        end
`endif
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

`ifdef ODELAY_TAP_CTL_READBACK_EN
  // Set wins over clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == ST_CHECK && cntvalueout != tap_now) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^{cntvalueout, err_clr};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_odelay_tap_ctl.sv
module tb_odelay_tap_ctl;

`ifdef ODELAY_TAP_CTL_READBACK_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int SETTLE = 4;
  localparam int P      = 1 + SETTLE + R;
  localparam int LIMIT  = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ramp-mode instance
  logic       rst, req_valid, req_ready, ld, done, err, err_clr;
  logic [4:0] req_tap, cntvaluein, cntvalueout, tap_now;
  // direct-mode instance
  logic       d_rst, d_req_valid, d_req_ready, d_ld, d_done, d_err, d_err_clr;
  logic [4:0] d_req_tap, d_cntvaluein, d_cntvalueout, d_tap_now;

  // delay element models; force_en corrupts the readback while tap 9 is loaded
  logic [4:0] cvo = '0, d_cvo = '0;
  logic       force_en = 1'b0;
  always @(posedge clk) if (ld)   cvo   <= cntvaluein;
  always @(posedge clk) if (d_ld) d_cvo <= d_cntvaluein;
  assign cntvalueout   = (force_en && tap_now == 5'd9) ? 5'd3 : cvo;
  assign d_cntvalueout = d_cvo;

  odelay_tap_ctl #(.TAP_W(5), .INIT_TAP(5'd7), .STEP_MODE(1'b1), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tap(req_tap), .req_ready(req_ready),
    .cntvaluein(cntvaluein), .ld(ld), .cntvalueout(cntvalueout), .tap_now(tap_now),
    .done(done), .err(err), .err_clr(err_clr));

  odelay_tap_ctl #(.TAP_W(5), .INIT_TAP(5'd31), .STEP_MODE(1'b0), .SETTLE_CYCLES(SETTLE)) u_dir (
    .clk(clk), .rst(d_rst), .req_valid(d_req_valid), .req_tap(d_req_tap), .req_ready(d_req_ready),
    .cntvaluein(d_cntvaluein), .ld(d_ld), .cntvalueout(d_cntvalueout), .tap_now(d_tap_now),
    .done(d_done), .err(d_err), .err_clr(d_err_clr));

  int errors = 0;
  int checks = 0;
  int q_main[$];
  int q_dir[$];
  int m_tap;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboards: every ld must match the next expected load value
  logic prev_ld = 1'b0, d_prev_ld = 1'b0;
  always @(negedge clk) begin
    if (ld) begin
      chk("ld_gap", int'(prev_ld), 0);
      if (q_main.size() == 0) chk("ld_unexpected", int'(ld), 0);
      else chk("ld_val", int'(cntvaluein), q_main.pop_front());
    end
    prev_ld <= ld;
  end
  always @(negedge clk) begin
    if (d_ld) begin
      chk("d_ld_gap", int'(d_prev_ld), 0);
      if (q_dir.size() == 0) chk("d_ld_unexpected", int'(d_ld), 0);
      else chk("d_ld_val", int'(d_cntvaluein), q_dir.pop_front());
    end
    d_prev_ld <= d_ld;
  end

  // called at the negedge of cycle 1 (accept edge = cycle 0)
  task automatic wait_main(input int exp_cyc, input string tag);
    int cyc = 1;
    while (!done && cyc <= LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    chk(tag, cyc, exp_cyc);
    chk({tag, "_ready"}, int'(req_ready), int'(done));
  endtask

  // hold_tap >= 0 keeps req_valid asserted with that tap for the busy period
  task automatic req_main(input int tgt, input int stop, input int hold_tap, input string tag);
    int n = 0;
    chk({tag, "_idle"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_tap   = 5'(tgt);
    while (m_tap != stop) begin
      m_tap += (stop > m_tap) ? 1 : -1;
      q_main.push_back(m_tap);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold_tap >= 0) req_tap = 5'(hold_tap);
    else req_valid = 1'b0;
    wait_main(n * P + 1, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; d_rst = 1'b1;
    req_valid = 1'b0; req_tap = '0; err_clr = 1'b0;
    d_req_valid = 1'b0; d_req_tap = '0; d_err_clr = 1'b0;
    m_tap = 7;
    q_main.push_back(7);
    q_dir.push_back(31);
    repeat (2) @(negedge clk);
    chk("rst_tap_now", int'(tap_now), 7);
    chk("rst_cntvaluein", int'(cntvaluein), 7);
    chk("rst_ld", int'(ld), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_d_tap_now", int'(d_tap_now), 31);

    // reset release: INIT loads INIT_TAP directly
    rst = 1'b0; d_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_main(P + 1, "init_done");
    chk("init_d_done", int'(d_done), 1);
    chk("init_tap_now", int'(tap_now), 7);
    @(negedge clk);

    // direct mode: 31 -> 0 in one load
    chk("dir_idle", int'(d_req_ready), 1);
    d_req_valid = 1'b1; d_req_tap = 5'd0;
    q_dir.push_back(0);
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    cnt = 1;
    while (!d_done && cnt <= LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    chk("dir_done_cycle", cnt, P + 1);
    chk("dir_tap_now", int'(d_tap_now), 0);
    @(negedge clk);

    // ramp up 7 -> 12 with req_valid held (other tap) while busy
    req_main(12, 12, 25, "ramp_up");
    chk("ramp_up_tap", int'(tap_now), 12);
    @(negedge clk);
    chk("held_req_ignored", int'(req_ready), 1);

    // request equal to current tap: no ld, done in cycle 1
    req_main(12, 12, -1, "equal");
    @(negedge clk);

    // ramp down 12 -> 3
    req_main(3, 3, -1, "ramp_down");
    chk("ramp_down_tap", int'(tap_now), 3);
    @(negedge clk);

`ifdef ODELAY_TAP_CTL_READBACK_EN
    // readback mismatch on step 9 aborts the ramp toward 12
    force_en = 1'b1;
    req_main(12, 9, -1, "rb_abort");
    force_en = 1'b0;
    chk("rb_err_set", int'(err), 1);
    chk("rb_tap_now", int'(tap_now), 9);
    @(negedge clk);
    chk("rb_err_sticky", int'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("rb_err_clr", int'(err), 0);
`else
    req_main(9, 9, -1, "ramp_to9");
    chk("no_rb_err", int'(err), 0);
`endif
    @(negedge clk);

    // asynchronous reset mid-ramp at tap 10 (target 20)
    chk("mid_idle", int'(req_ready), 1);
    req_valid = 1'b1; req_tap = 5'd20;
    for (int t = 10; t <= 20; t++) q_main.push_back(t);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (tap_now != 5'd10 && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_tap10", int'(tap_now), 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ld", int'(ld), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    chk("mid_rst_tap", int'(tap_now), 7);
    chk("mid_rst_cvi", int'(cntvaluein), 7);
    q_main.delete();
    q_main.push_back(7);
    m_tap = 7;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_main(P + 1, "rst_reload");
    chk("rst_reload_tap", int'(tap_now), 7);
    @(negedge clk);

    // boundaries: up to 31, then 31 -> 0 by decrements only
    req_main(31, 31, -1, "ramp_to31");
    @(negedge clk);
    req_main(0, 0, -1, "ramp_31to0");
    chk("final_tap", int'(tap_now), 0);
    @(negedge clk);
    chk("q_main_empty", q_main.size(), 0);
    chk("q_dir_empty", q_dir.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
